// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and helpers for the handshaked multi-cycle ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_AND  = 4'd2;
  localparam logic [3:0] FN_OR   = 4'd3;
  localparam logic [3:0] FN_XOR  = 4'd4;
  localparam logic [3:0] FN_NOR  = 4'd5;
  localparam logic [3:0] FN_SLT  = 4'd6;
  localparam logic [3:0] FN_BEQ  = 4'd7;
  localparam logic [3:0] FN_BNE  = 4'd8;
  localparam logic [3:0] FN_BLT  = 4'd9;
  localparam logic [3:0] FN_BGT  = 4'd10;
  localparam logic [3:0] FN_SLTU = 4'd11;
  localparam logic [3:0] FN_MUL  = 4'd12;
  localparam logic [3:0] FN_DIVU = 4'd13;
  localparam logic [3:0] FN_REMU = 4'd14;
  localparam logic [3:0] FN_BAD  = 4'hF;

  // Handshake FSM of the top level.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation selector for the iterative multiply/divide unit.
  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_t;

  // Op codes served by the iterative unit (may still complete in one cycle
  // when a divide sees a zero divisor).
  function automatic logic is_multicycle(input logic [3:0] fn);
    return (fn == FN_MUL) || (fn == FN_DIVU) || (fn == FN_REMU);
  endfunction

  // Maps an iterative op code onto the sub-unit selector.
  function automatic md_op_t to_md_op(input logic [3:0] fn);
    md_op_t op;
    op = MD_REMU;
    if (fn == FN_MUL) op = MD_MUL;
    else if (fn == FN_DIVU) op = MD_DIVU;
    return op;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add, low WIDTH bits) and restoring divide, one bit per cycle.
// Latency: WIDTH cycles after start; done marks the cycle whose edge completes the final step.
// Backpressure: none; caller must not pulse start while busy.
//
// Ports: clk, rst_n (async active-low); start/op/a/b load a new operation;
//        busy high while iterating; done high during the last iteration step;
//        res is the final value, valid only while done is high.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // acc_q : product accumulator (MUL) or partial remainder (DIVU/REMU)
  // opa_q : multiplicand shifted left (MUL) or dividend/quotient shift register (DIV)
  // opb_q : multiplier shifted right (MUL) or the divisor (DIV)
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [WIDTH-1:0] acc_nx, opa_nx, opb_nx;
  logic [WIDTH:0]   rem_sh, diff;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  md_op_t           op_q;

  always_comb begin
    acc_nx = acc_q;
    opa_nx = opa_q;
    opb_nx = opb_q;
    rem_sh = '0;
    diff   = '0;
    if (op_q == MD_MUL) begin
      acc_nx = acc_q + (opb_q[0] ? opa_q : '0);
      opa_nx = opa_q << 1;
      opb_nx = opb_q >> 1;
    end else begin
      // Bring the next dividend bit into the remainder and trial-subtract.
      // The extra top bit of diff is the borrow: set means "does not fit".
      rem_sh = {acc_q, opa_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, opb_q};
      acc_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      opa_nx = {opa_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign res  = (op_q == MD_DIVU) ? opa_nx : acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= MD_MUL;
    end else if (start) begin
      acc_q  <= '0;
      opa_q  <= a;
      opb_q  <= b;
      op_q   <= op;
      cnt_q  <= CNT_W'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_nx;
      opa_q <= opa_nx;
      opb_q <= opb_nx;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked EX-stage ALU: registered single-cycle ops plus iterative MUL/DIVU/REMU.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for MUL/DIVU/REMU.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one bubble per op).
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready + func/first_operand/second_operand
//        form the request; out_valid/out_ready + result/do_branch/bad_func form the response.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] first_operand,
  input  logic [WIDTH-1:0] second_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             do_branch,
  output logic             bad_func
);

  state_t           state_q, state_d;
  logic             accept;
  logic             md_start, md_busy, md_done;
  logic [WIDTH-1:0] md_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_br, sc_bad;
  logic             lt_s, lt_u, eq;

  assign accept = in_valid && in_ready;

  // A divide by zero never enters the iterative unit; its fixed answer comes
  // from the single-cycle mux and it completes like any one-cycle op.
  assign md_start = accept && is_multicycle(func) &&
                    !((func != FN_MUL) && (second_operand == '0));

  // ---------------------------------------------------------------------------
  // Single-cycle operation mux
  // ---------------------------------------------------------------------------
  assign lt_s = $signed(first_operand) < $signed(second_operand);
  assign lt_u = first_operand < second_operand;
  assign eq   = first_operand == second_operand;

  always_comb begin
    sc_res = '0;
    sc_br  = 1'b0;
    sc_bad = 1'b0;
    unique case (func)
      FN_ADD:  sc_res = first_operand + second_operand;
      FN_SUB:  sc_res = first_operand - second_operand;
      FN_AND:  sc_res = first_operand & second_operand;
      FN_OR:   sc_res = first_operand | second_operand;
      FN_XOR:  sc_res = first_operand ^ second_operand;
      FN_NOR:  sc_res = ~(first_operand | second_operand);
      FN_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt_s};
      FN_SLTU: sc_res = {{(WIDTH-1){1'b0}}, lt_u};
      FN_BEQ:  sc_br  = eq;
      FN_BNE:  sc_br  = !eq;
      FN_BLT:  sc_br  = lt_s;
      FN_BGT:  sc_br  = !lt_s && !eq;
      FN_MUL:  sc_res = '0;
      // Only reach the output registers when the divisor is zero.
      FN_DIVU: sc_res = '1;
      FN_REMU: sc_res = first_operand;
      FN_BAD:  sc_bad = 1'b1;
      default: sc_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide
  // ---------------------------------------------------------------------------
  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (to_md_op(func)),
    .a     (first_operand),
    .b     (second_operand),
    .busy  (md_busy),
    .done  (md_done),
    .res   (md_res)
  );

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The iterative unit is idle whenever the FSM is; the extra term keeps
        // a stray busy unit from ever being handed a second operation.
        in_ready = !md_busy;
        if (accept) begin
          state_d = md_start ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers: loaded only on accept or on the last iteration, so they
  // hold their value through DONE and on into the following IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      do_branch <= 1'b0;
      bad_func  <= 1'b0;
    end else if (accept) begin
      do_branch <= sc_br;
      bad_func  <= sc_bad;
      if (!md_start) begin
        result <= sc_res;
      end
    end else if ((state_q == ST_BUSY) && md_done) begin
      result <= md_res;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized + directed self-checking bench for alu_mc against a plain-arithmetic reference model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low for random spans.
module tb_alu_mc;

  localparam int W = 16;
  localparam logic [W-1:0] MASK = '1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   func;
  logic [W-1:0] first_operand;
  logic [W-1:0] second_operand;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         do_branch;
  logic         bad_func;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .func           (func),
    .first_operand  (first_operand),
    .second_operand (second_operand),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .do_branch      (do_branch),
    .bad_func       (bad_func)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: returns {bad_func, do_branch, result}.
  function automatic logic [W+1:0] ref_model(input int f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, r;
    int     sa, sb;
    logic   br, bad;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (a >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
    sb  = (b >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
    r   = 0;
    br  = 1'b0;
    bad = 1'b0;
    case (f)
      0:  r = ua + ub;
      1:  r = ua - ub + (longint'(1) << W);
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = ua ^ ub;
      5:  r = ~(ua | ub);
      6:  r = (sa < sb) ? 1 : 0;
      7:  br = (ua == ub);
      8:  br = (ua != ub);
      9:  br = (sa < sb);
      10: br = (sa > sb);
      11: r = (ua < ub) ? 1 : 0;
      12: r = ua * ub;
      13: r = (ub == 0) ? longint'(MASK) : ua / ub;
      14: r = (ub == 0) ? ua : ua % ub;
      default: bad = 1'b1;
    endcase
    return {bad, br, W'(r)};
  endfunction

  // Offer one operation, wait for the result, hold it for `hold` cycles with
  // out_ready low, then consume it and check the return to idle.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    logic [W+1:0] exp;
    int exp_lat, cyc;
    exp     = ref_model(int'(f), a, b);
    exp_lat = ((f == 4'd12) || ((f == 4'd13 || f == 4'd14) && b != 0)) ? W + 1 : 1;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid       = 1'b1;
    func           = f;
    first_operand  = a;
    second_operand = b;
    out_ready      = 1'b0;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the unit must have latched them.
    in_valid       = 1'b0;
    func           = 4'($urandom);
    first_operand  = W'($urandom);
    second_operand = W'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!out_valid) check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    end while (!out_valid && cyc < 200);
    if (!out_valid) begin
      check({tag, ".timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".result"}, 32'(result), 32'(exp[W-1:0]));
    check({tag, ".do_branch"}, 32'(do_branch), 32'(exp[W]));
    check({tag, ".bad_func"}, 32'(bad_func), 32'(exp[W+1]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_result"}, {bad_func, do_branch, 14'd0, result}, {exp[W+1], exp[W], 14'd0, exp[W-1:0]});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    func           = 4'd0;
    first_operand  = '0;
    second_operand = '0;
    out_ready      = 1'b0;
    #3;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.result", 32'(result), 32'd0);
    check("reset.flags", {30'd0, do_branch, bad_func}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 0);
    do_op("slt", 4'd6, 16'h8000, 16'h0001, 0);
    do_op("sltu", 4'd11, 16'h8000, 16'h0001, 0);
    do_op("blt", 4'd9, 16'hFFFE, 16'h0002, 0);
    do_op("bgt_eq", 4'd10, 16'h0007, 16'h0007, 1);
    do_op("mul", 4'd12, 16'h0123, 16'h0010, 0);
    do_op("mul_full", 4'd12, 16'hFFFF, 16'hFFFF, 2);
    do_op("divu", 4'd13, 16'd100, 16'd7, 0);
    do_op("remu", 4'd14, 16'd100, 16'd7, 0);
    do_op("divu_big", 4'd13, 16'hFFFF, 16'h0001, 0);
    do_op("divu_z", 4'd13, 16'h1234, 16'h0000, 0);
    do_op("remu_z", 4'd14, 16'h1234, 16'h0000, 0);

    // Backpressure with an upstream that keeps offering during DONE.
    @(negedge clk);
    in_valid = 1'b1; func = 4'd7; first_operand = 16'd5; second_operand = 16'd5;
    @(posedge clk);
    #1;
    func = 4'd0; first_operand = 16'd2; second_operand = 16'd3;
    @(negedge clk);
    check("bp.first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp.hold", {29'd0, out_valid, do_branch, in_ready}, 32'b110);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.bubble", {30'd0, out_valid, in_ready}, 32'b01);
    check("bp.bubble_result", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp.second_valid", 32'(out_valid), 32'd1);
    check("bp.second_result", {15'd0, do_branch, result}, 32'd5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; func = 4'd12; first_operand = 16'h0123; second_operand = 16'h0010;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.state", {30'd0, out_valid, in_ready}, 32'b01);
    check("rst_mid.result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid.no_late", 32'(out_valid), 32'd0);
    do_op("add_after_rst", 4'd0, 16'd2, 16'd3, 0);
    do_op("bad", 4'hF, 16'h5555, 16'hAAAA, 1);

    // Randomized operations
    for (int n = 0; n < 150; n++) begin
      logic [3:0]   f;
      logic [W-1:0] a, b;
      f = 4'($urandom_range(0, 15));
      a = W'($urandom);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        2:       b = a;
        default: b = W'($urandom);
      endcase
      do_op("rand", f, a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
